bicubic_nx_round_sat: RTL and testbench

- Next-generation parallel rounding stage for the Bicubic pipeline.
- Takes LANES signed accumulator words per beat, one set per colour channel.
- For each word: adds a mode-dependent rounding bias, arithmetic-shifts right by RSHIFT_RANGE, then clamps to the output pixel range.
- Adds a valid/ready handshake with full back-pressure, a per-beat rounding mode and saturation flags; sits between the bicubic MAC array and the pixel packer.

---
 rtl/bicubic_round_pkg.sv | 24 ++
 rtl/bicubic_round_lane.sv | 77 +++++++
 rtl/bicubic_nx_round_sat.sv | 100 ++++++++++
 tb/tb_bicubic_nx_round_sat.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_round_pkg.sv
// Shared definitions for the bicubic rounding/saturation stage.
//   round_mode_t    : per-beat rounding mode encoding (code 3 behaves as trunc)
//   clamp_limit()   : signed clamp bound for a given output width / clamp style
//   SAT_COUNT_WIDTH : width of the saturation event counter
package bicubic_round_pkg;

  localparam int SAT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ROUND_TRUNC     = 2'd0,
    ROUND_HALF_UP   = 2'd1,
    ROUND_HALF_EVEN = 2'd2
  } round_mode_t;

  // want_max=1 returns the upper bound, otherwise the lower bound.
  // Unsigned clamping keeps the signed output format but never goes below 0.
  function automatic longint clamp_limit(input int ow, input bit uc, input bit want_max);
    longint half;
    half = longint'(1) << (ow - 1);
    if (want_max) return half - 1;
    return uc ? longint'(0) : -half;
  endfunction

endpackage

// File: rtl/bicubic_round_lane.sv
// One lane of the rounding stage: bias add (S1), arithmetic shift + clamp (S2).
// Ports:
//   clk, dsp_reset : clock, synchronous active-high reset
//   load           : pipeline advance; both stages load only when set
//   mode           : rounding mode captured with the input word
//   x              : signed accumulator word
//   y              : clamped signed result (S2 register)
//   sat            : clamp was applied to y (S2 register)
module bicubic_round_lane
  import bicubic_round_pkg::*;
#(
  parameter int INPUT_WIDTH    = 48,
  parameter int RSHIFT_RANGE   = 8,
  parameter int OUTPUT_WIDTH   = 9,
  parameter int UNSIGNED_CLAMP = 1
) (
  input  logic                          clk,
  input  logic                          dsp_reset,
  input  logic                          load,
  input  logic [1:0]                    mode,
  input  logic signed [INPUT_WIDTH-1:0] x,
  output logic [OUTPUT_WIDTH-1:0]       y,
  output logic                          sat
);

  localparam int SW = INPUT_WIDTH + 1;
  localparam logic signed [SW-1:0] CMAX = SW'(clamp_limit(OUTPUT_WIDTH, UNSIGNED_CLAMP != 0, 1'b1));
  localparam logic signed [SW-1:0] CMIN = SW'(clamp_limit(OUTPUT_WIDTH, UNSIGNED_CLAMP != 0, 1'b0));
  localparam logic signed [SW-1:0] HALF = {{(SW-1){1'b0}}, 1'b1} << (RSHIFT_RANGE - 1);

  logic signed [SW-1:0]     bias;
  logic signed [SW-1:0]     sum_next;
  logic signed [SW-1:0]     s1_sum;
  logic signed [SW-1:0]     shifted;
  logic [OUTPUT_WIDTH-1:0]  clamped;
  logic                     sat_next;

  // Half-even: bias one short of half, plus the LSB that survives the shift,
  // so exact ties round towards the even result.
  always_comb begin
    bias = '0;
    case (mode)
      ROUND_HALF_UP:   bias = HALF;
      ROUND_HALF_EVEN: bias = HALF - SW'(1) + SW'(x[RSHIFT_RANGE]);
      default:         bias = '0;
    endcase
  end

  // One extra bit of headroom so the biased sum cannot wrap.
  assign sum_next = {x[INPUT_WIDTH-1], x} + bias;
  assign shifted  = s1_sum >>> RSHIFT_RANGE;

  always_comb begin
    clamped  = shifted[OUTPUT_WIDTH-1:0];
    sat_next = 1'b0;
    if (shifted > CMAX) begin
      clamped  = CMAX[OUTPUT_WIDTH-1:0];
      sat_next = 1'b1;
    end else if (shifted < CMIN) begin
      clamped  = CMIN[OUTPUT_WIDTH-1:0];
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (dsp_reset) begin
      s1_sum <= '0;
      y      <= '0;
      sat    <= 1'b0;
    end else if (load) begin
      s1_sum <= sum_next;
      y      <= clamped;
      sat    <= sat_next;
    end
  end

endmodule

// File: rtl/bicubic_nx_round_sat.sv
// Parallel rounding/saturation stage between the bicubic MAC array and the
// pixel packer. Two-stage pipeline with valid/ready and full back-pressure.
// Ports:
//   clk, dsp_reset        : clock, synchronous active-high reset
//   clken                 : global enable; all state holds when low
//   in_valid/in_ready     : input handshake; in_mode/in_data sampled on accept
//   out_valid/out_ready   : output handshake; out_data/out_sat held while stalled
//   out_sat               : per-lane clamp-applied flags
//   sat_clear             : clears sat_sticky/sat_count
//   sat_sticky, sat_count : saturation status, present only when
//                           BICUBIC_ROUND_SAT_STATUS_EN is defined, else tied 0
module bicubic_nx_round_sat
  import bicubic_round_pkg::*;
#(
  parameter int PARALLEL_CORE  = 2,
  parameter int CHANNELS       = 3,
  parameter int INPUT_WIDTH    = 48,
  parameter int RSHIFT_RANGE   = 8,
  parameter int OUTPUT_WIDTH   = 9,
  parameter int UNSIGNED_CLAMP = 1,
  localparam int LANES         = PARALLEL_CORE * CHANNELS
) (
  input  logic                          clk,
  input  logic                          dsp_reset,
  input  logic                          clken,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_mode,
  input  logic [INPUT_WIDTH*LANES-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUTPUT_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]              out_sat,
  input  logic                          sat_clear,
  output logic                          sat_sticky,
  output logic [SAT_COUNT_WIDTH-1:0]    sat_count
);

  logic adv;
  logic s1_valid;
  logic s2_valid;

  // Bubbles are not squeezed out: the whole pipe moves or nothing moves.
  assign adv       = clken && (!s2_valid || out_ready);
  assign in_ready  = adv && !dsp_reset;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (dsp_reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bicubic_round_lane #(
      .INPUT_WIDTH   (INPUT_WIDTH),
      .RSHIFT_RANGE  (RSHIFT_RANGE),
      .OUTPUT_WIDTH  (OUTPUT_WIDTH),
      .UNSIGNED_CLAMP(UNSIGNED_CLAMP)
    ) u_lane (
      .clk      (clk),
      .dsp_reset(dsp_reset),
      .load     (adv),
      .mode     (in_mode),
      .x        (in_data[k*INPUT_WIDTH +: INPUT_WIDTH]),
      .y        (out_data[k*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
      .sat      (out_sat[k])
    );
  end

`ifdef BICUBIC_ROUND_SAT_STATUS_EN
  logic sat_event;

  // Gated by clken so a beat held across a disabled cycle counts only once.
  assign sat_event = clken && s2_valid && out_ready && (|out_sat);

  always_ff @(posedge clk) begin
    if (dsp_reset) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (clken && sat_clear) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (sat_event) begin
      sat_sticky <= 1'b1;
      if (sat_count != {SAT_COUNT_WIDTH{1'b1}}) sat_count <= sat_count + 1'b1;
    end
  end
`else
  logic unused_sat_clear;
  assign unused_sat_clear = sat_clear;
  assign sat_sticky       = 1'b0;
  assign sat_count        = '0;
`endif

endmodule

// File: tb/tb_bicubic_nx_round_sat.sv
module tb_bicubic_nx_round_sat;
  localparam int IW = 48;
  localparam int L  = 6;
  localparam int OW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              dsp_reset, clken, in_valid, out_ready, sat_clear;
  logic [1:0]        in_mode;
  logic [IW*L-1:0]   in_data;

  logic              in_ready, out_valid, sat_sticky;
  logic [OW*L-1:0]   out_data;
  logic [L-1:0]      out_sat;
  logic [15:0]       sat_count;

  logic              in_ready_s, out_valid_s, sat_sticky_s;
  logic [OW*L-1:0]   out_data_s;
  logic [L-1:0]      out_sat_s;
  logic [15:0]       sat_count_s;

  int checks = 0;
  int errors = 0;

  bicubic_nx_round_sat u0 (
    .clk(clk), .dsp_reset(dsp_reset), .clken(clken),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_clear(sat_clear), .sat_sticky(sat_sticky), .sat_count(sat_count)
  );

  bicubic_nx_round_sat #(.UNSIGNED_CLAMP(0)) u1 (
    .clk(clk), .dsp_reset(dsp_reset), .clken(clken),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_sat(out_sat_s),
    .sat_clear(sat_clear), .sat_sticky(sat_sticky_s), .sat_count(sat_count_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one beat (lane 0 = x, other lanes 0) and wait until it reaches S2.
  task automatic send_one(input logic signed [IW-1:0] x, input logic [1:0] mode);
    in_data = '0;
    in_data[IW-1:0] = x;
    in_mode  = mode;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  // Stream n beats (lane 0 value k+1) under per-cycle ready/clken patterns.
  task automatic run_stream(input int n, input logic [63:0] rdy_pat,
                            input logic [63:0] ck_pat, input string tag);
    int sent;
    int rcvd;
    logic pv, pr, pc;
    logic [OW-1:0] pd;
    sent = 0;
    rcvd = 0;
    pv = out_valid; pr = 1'b1; pc = 1'b1; pd = out_data[OW-1:0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      out_ready = rdy_pat[cyc];
      clken     = ck_pat[cyc];
      in_mode   = 2'd0;
      in_valid  = (sent < n);
      in_data   = '0;
      in_data[IW-1:0] = IW'((sent + 1) * 256);
      #1;
      if (!pc || (pv && !pr)) begin
        check({tag, "_hold_valid"}, 64'(out_valid), 64'(pv));
        check({tag, "_hold_data"}, 64'(out_data[OW-1:0]), 64'(pd));
      end
      if (!clken) check({tag, "_clken_ready"}, 64'(in_ready), 64'd0);
      if (in_valid && in_ready) sent++;
      if (clken && out_valid && out_ready) begin
        check({tag, "_order"}, 64'(out_data[OW-1:0]), 64'(rcvd + 1));
        rcvd++;
      end
      pv = out_valid; pr = out_ready; pc = clken; pd = out_data[OW-1:0];
      tick();
      if (sent == n && rcvd == n) break;
    end
    in_valid  = 1'b0;
    clken     = 1'b1;
    out_ready = 1'b1;
    check({tag, "_count"}, 64'(rcvd), 64'(n));
    check({tag, "_no_extra"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic signed [IW-1:0] m_x   [7];
  logic [1:0]           m_md  [7];
  logic [8:0]           m_exp [7];
  logic [OW*L-1:0]      exp_data;

  initial begin
    dsp_reset = 1'b1; clken = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sat_clear = 1'b0; in_mode = 2'd0; in_data = '0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    check("rst_sat_sticky", 64'(sat_sticky), 64'd0);
    dsp_reset = 1'b0;
    tick();

    // 1.5 and 2.5 under each mode; mode 3 behaves as trunc
    m_x = '{384, 384, 384, 640, 640, 640, 640};
    m_md = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    m_exp = '{9'd1, 9'd2, 9'd2, 9'd2, 9'd3, 9'd2, 9'd2};
    for (int i = 0; i < 7; i++) begin
      send_one(m_x[i], m_md[i]);
      check($sformatf("mode_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("mode_data_%0d", i), 64'(out_data[OW-1:0]), 64'(m_exp[i]));
      check($sformatf("mode_sat_%0d", i), 64'(out_sat[0]), 64'd0);
    end

    // -1.5: signed clamp keeps the rounded value, unsigned clamp pins to 0
    m_exp[0] = 9'h1FE; m_exp[1] = 9'h1FF; m_exp[2] = 9'h1FE;
    for (int i = 0; i < 3; i++) begin
      send_one(-384, 2'(i));
      check($sformatf("neg_signed_%0d", i), 64'(out_data_s[OW-1:0]), 64'(m_exp[i]));
      check($sformatf("neg_signed_sat_%0d", i), 64'(out_sat_s[0]), 64'd0);
      check($sformatf("neg_unsigned_%0d", i), 64'(out_data[OW-1:0]), 64'd0);
      check($sformatf("neg_unsigned_sat_%0d", i), 64'(out_sat[0]), 64'd1);
    end

    send_one(76800, 2'd0);
    check("sat_300_data", 64'(out_data[OW-1:0]), 64'd255);
    check("sat_300_flag", 64'(out_sat), 64'h01);
    check("sat_300_signed", 64'(out_data_s[OW-1:0]), 64'd255);

    // All lanes distinct; lane 5 saturates
    in_data  = '0;
    exp_data = '0;
    for (int k = 0; k < 5; k++) begin
      in_data[k*IW +: IW]  = IW'((k * 10 + 1) * 256);
      exp_data[k*OW +: OW] = OW'(k * 10 + 1);
    end
    in_data[5*IW +: IW]  = IW'(1000 * 256);
    exp_data[5*OW +: OW] = OW'(255);
    in_mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("lanes_data", 64'(out_data), 64'(exp_data));
    check("lanes_sat", 64'(out_sat), 64'h20);
    drain();

    run_stream(10, 64'hB5A3_6C9D_E14F_72A9, 64'hFFFF_FFFF_FFFF_FFFF, "bp");
    run_stream(6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF8F, "ck");

    // Reset with both stages full
    out_ready = 1'b0;
    in_data = '0; in_data[IW-1:0] = 76800; in_mode = 2'd0; in_valid = 1'b1;
    tick();
    tick();
    check("mid_full_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    dsp_reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_sat", 64'(out_sat), 64'd0);
    check("mid_rst_count", 64'(sat_count), 64'd0);
    check("mid_rst_sticky", 64'(sat_sticky), 64'd0);
    dsp_reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("mid_rst_flushed_%0d", i), 64'(out_valid), 64'd0);
    end

    // Status: three saturated handshakes, then a fourth with sat_clear
    for (int i = 0; i < 3; i++) send_one(76800, 2'd0);
    tick();
`ifdef BICUBIC_ROUND_SAT_STATUS_EN
    check("status_count3", 64'(sat_count), 64'd3);
    check("status_sticky", 64'(sat_sticky), 64'd1);
`else
    check("status_count_off", 64'(sat_count), 64'd0);
    check("status_sticky_off", 64'(sat_sticky), 64'd0);
`endif
    send_one(76800, 2'd0);
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    check("status_clear_count", 64'(sat_count), 64'd0);
    check("status_clear_sticky", 64'(sat_sticky), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
